rtc_access_sequencer: RTL
=========================

// Module: rtc_access_sequencer
// PURPOSE
//  Sequences all accesses to the RTC register bus engine for the date/time display path.
//  Runs periodic 6-register read bursts (seg, min, hora, dia, mes, year) into the display registers.
//  Grants editing to the date or time edit block and writes the edited BCD values back on commit.
//  Arbitrates commit writes against refresh reads; one transaction is outstanding at a time.
// PARAMETERS
//  REFRESH_CYC  10_000_000  clk cycles between read bursts (100 ms @ 100 MHz); minimum value 16
//  TMR_W        24          refresh timer width; must satisfy 2**TMR_W > REFRESH_CYC
// PORTS
//  clk           in   1  system clock, all logic on rising edge
//  reset         in   1  asynchronous, active-high reset
//  mode_fecha    in   1  user selects date editing (level)
//  mode_hora     in   1  user selects time editing (level)
//  commit        in   1  user confirms the edit (level; acts on rising edge)
//  diaC,mesC,yearC in 8 each  edited BCD date from the date edit block
//  horaC,minC,segC in 8 each  edited BCD time from the time edit block
//  bus_ack       in   1  one-cycle pulse from the bus engine: transaction done
//  bus_rdata     in   8  read data, valid in the bus_ack cycle
//  bus_req       out  1  transaction request, held until bus_ack
//  bus_wr        out  1  1 = write, 0 = read; stable while bus_req is high
//  bus_addr      out  8  RTC register address; stable while bus_req is high
//  bus_wdata     out  8  write data; stable while bus_req is high
//  dia,mes,year  out  8 each  display date (BCD)
//  hora,min,seg  out  8 each  display time (BCD)
//  en_fecha      out  1  enable to the date edit block
//  en_hora       out  1  enable to the time edit block
//  busy          out  1  high whenever the FSM is not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; idx=0; commit_q=0; pend_commit=0; timer=0 (expired).
//   Reset is asynchronous: bus_req drops immediately, even mid-transaction; no partial burst completes.
//  Edit grant (registered, 1-cycle lag):
//   - en_fecha = mode_fecha.
//   - en_hora = mode_hora & ~mode_fecha. Date editing wins when both modes are high.
//   - Refresh bursts are suppressed while either enable is high; the timer holds at 0.
//  Commit: on the rising edge of commit (commit & ~commit_q), set pend_commit and latch the target:
//   - target = date if en_fecha, time if en_hora.
//   - If neither enable is high, the edge is ignored.
//  FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, GAP.
//   IDLE -> WR_REQ when pend_commit (priority over refresh).
//   IDLE -> RD_REQ when timer==0 and no edit enable.
//   RD_REQ: bus_req=1, bus_wr=0, bus_addr=RD_ADDR[idx]; go to RD_WAIT.
//   RD_WAIT: on bus_ack, load bus_rdata into the display register for idx and drop bus_req.
//     If idx==5: idx<=0, timer<=REFRESH_CYC-1, go to GAP. Otherwise idx++, go to GAP, then RD_REQ.
//   WR_REQ/WR_WAIT: 3 writes, date (dia,mes,year) or time (hora,min,seg), from the C inputs sampled in the write's REQ cycle.
//     On each ack, copy the written value into the matching display register.
//     After the 3rd ack: pend_commit<=0, timer<=0 (forces an immediate re-read), go to GAP then IDLE.
//   GAP: exactly one cycle with bus_req=0 between any two transactions.
//  A commit edge during a read burst only sets pend_commit; the burst finishes first.
//  A second commit edge while pend_commit is set is ignored.
//  Timer: decrements in IDLE when nonzero; never wraps below 0.
//  bus_ack outside RD_WAIT/WR_WAIT is ignored.
//  No timeout: the bus engine guarantees ack.
//  busy = (state != IDLE).
// STRUCTURE
//  Package rtc_pkg holds:
//   - Address constants ADDR_SEG=8'h21, ADDR_MIN=8'h22, ADDR_HORA=8'h23, ADDR_DIA=8'h24, ADDR_MES=8'h25, ADDR_YEAR=8'h26.
//   - RD_ADDR order: seg, min, hora, dia, mes, year.
//   - The FSM state encoding.
//  One sub-module, rtc_refresh_timer: load, decrement, zero flag.
// TESTING
//  Release reset, ack each read 3 cycles after bus_req with rdata = 8'h10 + idx.
//   -> addrs 21..26 in order, seg=10 ... year=15, 1-cycle gaps, next burst after REFRESH_CYC.
//  mode_fecha=1, diaC=8'h31, mesC=8'h12, yearC=8'h24, commit pulse.
//   -> writes 24=31, 25=12, 26=24 with bus_wr=1; display updated; a read burst follows.
//  Commit edge during the 3rd read of a burst.
//   -> remaining 3 reads complete, then 3 writes; no transaction is dropped.
//  mode_fecha=mode_hora=1.
//   -> en_fecha=1, en_hora=0; commit writes date addresses only; no refresh while held.
//  Assert reset while RD_WAIT is outstanding.
//   -> bus_req=0 in the same cycle; all outputs 0; after release, the burst restarts at addr 21.
//  commit edge with both modes low, and a stray bus_ack in IDLE.
//   -> no write issued, state unchanged.

Source files
------------

// File: rtl/rtc_access_sequencer_pkg.sv
// Shared constants and types for the RTC access sequencer:
// RTC register addresses, display slot order and FSM state encoding.
package rtc_pkg;

  localparam logic [7:0] ADDR_SEG  = 8'h21;
  localparam logic [7:0] ADDR_MIN  = 8'h22;
  localparam logic [7:0] ADDR_HORA = 8'h23;
  localparam logic [7:0] ADDR_DIA  = 8'h24;
  localparam logic [7:0] ADDR_MES  = 8'h25;
  localparam logic [7:0] ADDR_YEAR = 8'h26;

  // Number of display registers; slot n is also read number n of a burst.
  localparam int NREG = 6;

  // Burst read order, indexed by slot: seg, min, hora, dia, mes, year.
  localparam logic [7:0] RD_ADDR [NREG] = '{ADDR_SEG, ADDR_MIN, ADDR_HORA,
                                           ADDR_DIA, ADDR_MES, ADDR_YEAR};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    GAP     = 3'd5
  } state_t;

  // Display slot touched by write number idx (0..2) of a commit.
  // Date commits write dia, mes, year; time commits write hora, min, seg.
  function automatic logic [2:0] wr_slot(input logic tgt_date, input logic [2:0] idx);
    return tgt_date ? (3'd3 + idx) : (3'd2 - idx);
  endfunction

endpackage

// File: rtl/rtc_access_sequencer_if.sv
// Request/acknowledge bus between the sequencer and the RTC bus engine.
interface rtc_access_sequencer_if;
  logic       bus_req;
  logic       bus_wr;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_ack;
  logic [7:0] bus_rdata;

  modport master (
    output bus_req, bus_wr, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_wr, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/rtc_refresh_timer.sv
// Down-counter that paces the periodic read bursts.
// Load has priority over decrement; the count saturates at zero.
module rtc_refresh_timer #(
  parameter int TMR_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [TMR_W-1:0] count_reg;

  // Count register: load, or decrement while nonzero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count_reg <= '0;
    else if (load)
      count_reg <= load_val;
    else if (dec && (count_reg != '0))
      count_reg <= count_reg - 1'b1;
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/rtc_access_sequencer.sv
// Sequences every RTC bus access for the date/time display: periodic
// six-register read bursts and three-register commit writes, one
// transaction at a time with a one-cycle idle gap between transactions.
module rtc_access_sequencer
  import rtc_pkg::*;
#(
  parameter int REFRESH_CYC = 10_000_000,
  parameter int TMR_W       = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode_fecha,
  input  logic                  mode_hora,
  input  logic                  commit,
  input  logic [7:0]            diaC,
  input  logic [7:0]            mesC,
  input  logic [7:0]            yearC,
  input  logic [7:0]            horaC,
  input  logic [7:0]            minC,
  input  logic [7:0]            segC,
  rtc_access_sequencer_if.master bus,
  output logic [7:0]            dia,
  output logic [7:0]            mes,
  output logic [7:0]            year,
  output logic [7:0]            hora,
  output logic [7:0]            min,
  output logic [7:0]            seg,
  output logic                  en_fecha,
  output logic                  en_hora,
  output logic                  busy
);

  state_t     state_reg, state_next;
  logic [2:0] idx_reg;
  logic       op_wr_reg;
  logic       tgt_date_reg;
  logic       pend_commit_reg;
  logic       commit_q_reg;
  logic       en_fecha_reg, en_hora_reg;
  logic [7:0] wdata_reg;
  logic [7:0] disp_reg [NREG];
  logic [7:0] c_vec [NREG];

  logic       edit_en;
  logic       is_wr_state;
  logic [2:0] cur_slot;
  logic       rd_ack, wr_ack, any_ack;
  logic       rd_last, wr_last;
  logic       commit_edge;
  logic       tmr_load, tmr_zero;
  logic [TMR_W-1:0] tmr_load_val;

  // Edit-block values in slot order so writes share the read indexing.
  assign c_vec[0] = segC;
  assign c_vec[1] = minC;
  assign c_vec[2] = horaC;
  assign c_vec[3] = diaC;
  assign c_vec[4] = mesC;
  assign c_vec[5] = yearC;

  assign edit_en     = en_fecha_reg | en_hora_reg;
  assign is_wr_state = (state_reg == WR_REQ) || (state_reg == WR_WAIT);
  assign cur_slot    = is_wr_state ? wr_slot(tgt_date_reg, idx_reg) : idx_reg;
  assign rd_ack      = (state_reg == RD_WAIT) && bus.bus_ack;
  assign wr_ack      = (state_reg == WR_WAIT) && bus.bus_ack;
  assign any_ack     = rd_ack | wr_ack;
  assign rd_last     = rd_ack && (idx_reg == 3'd5);
  assign wr_last     = wr_ack && (idx_reg == 3'd2);
  assign commit_edge = commit & ~commit_q_reg;

  // Editing pins the timer at zero so a refresh runs as soon as editing ends;
  // a finished burst rearms the full period; a finished commit forces a re-read.
  assign tmr_load     = edit_en | rd_last | wr_last;
  assign tmr_load_val = (rd_last && !edit_en) ? TMR_W'(REFRESH_CYC - 1) : '0;

  rtc_refresh_timer #(
    .TMR_W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (state_reg == IDLE),
    .zero     (tmr_zero)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next state and bus outputs; bus signals decode from state so reset drops them at once.
  always_comb begin
    state_next    = state_reg;
    bus.bus_req   = 1'b0;
    bus.bus_wr    = 1'b0;
    bus.bus_addr  = 8'h00;
    bus.bus_wdata = 8'h00;
    case (state_reg)
      IDLE: begin
        if (pend_commit_reg)
          state_next = WR_REQ;
        else if (tmr_zero && !edit_en)
          state_next = RD_REQ;
      end
      RD_REQ: begin
        bus.bus_req  = 1'b1;
        bus.bus_addr = RD_ADDR[cur_slot];
        state_next   = RD_WAIT;
      end
      RD_WAIT: begin
        bus.bus_req  = 1'b1;
        bus.bus_addr = RD_ADDR[cur_slot];
        if (bus.bus_ack)
          state_next = GAP;
      end
      WR_REQ: begin
        bus.bus_req   = 1'b1;
        bus.bus_wr    = 1'b1;
        bus.bus_addr  = RD_ADDR[cur_slot];
        bus.bus_wdata = c_vec[cur_slot];
        state_next    = WR_WAIT;
      end
      WR_WAIT: begin
        bus.bus_req   = 1'b1;
        bus.bus_wr    = 1'b1;
        bus.bus_addr  = RD_ADDR[cur_slot];
        bus.bus_wdata = wdata_reg;
        if (bus.bus_ack)
          state_next = GAP;
      end
      GAP: begin
        // idx returns to 0 only after the last transfer of a burst or commit.
        if (idx_reg == 3'd0)
          state_next = IDLE;
        else if (op_wr_reg)
          state_next = WR_REQ;
        else
          state_next = RD_REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control registers: edit grant, commit capture, transfer index and write data hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_q_reg    <= 1'b0;
      en_fecha_reg    <= 1'b0;
      en_hora_reg     <= 1'b0;
      pend_commit_reg <= 1'b0;
      tgt_date_reg    <= 1'b0;
      op_wr_reg       <= 1'b0;
      idx_reg         <= 3'd0;
      wdata_reg       <= 8'h00;
    end else begin
      commit_q_reg <= commit;
      en_fecha_reg <= mode_fecha;
      en_hora_reg  <= mode_hora & ~mode_fecha;
      if (commit_edge && !pend_commit_reg && edit_en) begin
        pend_commit_reg <= 1'b1;
        tgt_date_reg    <= en_fecha_reg;
      end else if (wr_last) begin
        pend_commit_reg <= 1'b0;
      end
      if (state_reg == IDLE)
        op_wr_reg <= pend_commit_reg;
      if (state_reg == WR_REQ)
        wdata_reg <= c_vec[cur_slot];
      if (any_ack)
        idx_reg <= (rd_last || wr_last) ? 3'd0 : (idx_reg + 3'd1);
    end
  end

  // Display registers: loaded from read data, or from the value just written.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_disp
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        disp_reg[gi] <= 8'h00;
      else if (any_ack && (cur_slot == 3'(gi)))
        disp_reg[gi] <= rd_ack ? bus.bus_rdata : wdata_reg;
    end
  end

  assign seg      = disp_reg[0];
  assign min      = disp_reg[1];
  assign hora     = disp_reg[2];
  assign dia      = disp_reg[3];
  assign mes      = disp_reg[4];
  assign year     = disp_reg[5];
  assign en_fecha = en_fecha_reg;
  assign en_hora  = en_hora_reg;
  assign busy     = (state_reg != IDLE);

endmodule
